// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer for the RV32I core.
// It handshakes with instruction memory, holds the instruction register, and gates register writes and PC advance.
module core_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          ir,
    output logic                 reg_write_en,
    output logic                 pc_inc,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_WRITEBACK = 3'b011,
        ST_TRAP      = 3'b100
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [31:0]          ir_q, ir_d;
    logic [7:0]           wait_q, wait_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 trap_q, trap_d;
    logic [1:0]           cause_q, cause_d;
    logic                 req_s, rwe_s, pc_inc_s;

    function automatic logic is_legal_opcode(input logic [6:0] opcode);
        return (opcode == 7'b0110011) || (opcode == 7'b0010011);
    endfunction

    // Next-state logic and unqualified strobes; stall freezes every non-trap state.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        req_s     = 1'b0;
        rwe_s     = 1'b0;
        pc_inc_s  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (!stall) begin
                    req_s = 1'b1;
                    // A ready on the limit cycle still counts as a successful fetch.
                    if (imem_ready) begin
                        ir_d    = imem_rdata;
                        wait_d  = 8'd0;
                        state_d = ST_DECODE;
                    end else if (wait_q == WAIT_LIMIT) begin
                        state_d = ST_TRAP;
                        trap_d  = 1'b1;
                        cause_d = 2'b10;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_DECODE: begin
                if (stall) begin
                    state_d = ST_DECODE;
                end else if (is_legal_opcode(ir_q[6:0])) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                end
            end
            ST_EXECUTE: begin
                if (!stall) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_WRITEBACK: begin
                if (!stall) begin
                    pc_inc_s  = 1'b1;
                    rwe_s     = (ir_q[11:7] != 5'd0);
                    retired_d = retired_q + CNT_WIDTH'(1);
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Output qualification: nothing is requested or strobed while reset is asserted.
    always_comb begin
        if (rst) begin
            imem_req     = 1'b0;
            reg_write_en = 1'b0;
            pc_inc       = 1'b0;
        end else begin
            imem_req     = req_s;
            reg_write_en = rwe_s;
            pc_inc       = pc_inc_s;
        end
    end

    // State and datapath-control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ir_q      <= 32'd0;
            wait_q    <= 8'd0;
            retired_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    assign ir            = ir_q;
    assign state         = state_q;
    assign retired_count = retired_q;
    assign trap          = trap_q;
    assign trap_cause    = cause_q;

endmodule
